mult_seq_arith: RTL and testbench
=================================

MULT_SEQ_ARITH -- requirements
Module: mult_seq_arith

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits.
REQ-002 Parameter DIGIT, default 16: digit width processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, DIGIT >= 1; N = WIDTH/DIGIT.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a multiplication; sampled only in IDLE.
REQ-006 signed_mode  input  1  1 = operands are two's complement, 0 = unsigned; sampled with start.
REQ-007 a  input  WIDTH  multiplicand; sampled with start.
REQ-008 b  input  WIDTH  multiplier; sampled with start.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  single-cycle pulse; product is valid while high.
REQ-011 product  output  2*WIDTH  registered result.

Function
REQ-012 FSM states SHALL be IDLE, RUN, SIGN and DONE.
REQ-013 IDLE: when start=1 at an edge, the block SHALL latch a, b and signed_mode, clear the accumulator, set step counter k=0, and move to RUN; otherwise it SHALL stay in IDLE.
REQ-014 Operand latch, signed_mode=1: the block SHALL store |a| and |b| as unsigned WIDTH-bit values.
REQ-015 Magnitude of -2^(WIDTH-1) SHALL be 2^(WIDTH-1), which fits in WIDTH bits.
REQ-016 Operand latch: the block SHALL record neg = a[MSB] XOR b[MSB] when signed_mode=1, and neg = 0 otherwise.
REQ-017 RUN, each edge: digit i = k mod N of |a| times digit j = k div N of |b| (DIGIT x DIGIT, 2*DIGIT-bit result), shifted left by (i+j)*DIGIT, SHALL be added to the 2*WIDTH-bit accumulator; k SHALL then increment.
REQ-018 RUN SHALL last exactly N*N edges; the edge processing k = N*N-1 SHALL move the FSM to SIGN.
REQ-019 Accumulator arithmetic SHALL be 2*WIDTH bits unsigned; no overflow is possible and none SHALL be flagged.
REQ-020 SIGN, one edge: product SHALL be loaded with the two's-complement negation of the accumulator if neg=1, else with the accumulator; the FSM SHALL then move to DONE.
REQ-021 DONE: done SHALL be 1 for exactly this one cycle; the next edge SHALL return the FSM to IDLE.
REQ-022 Latency: with start accepted at edge E0, done SHALL be high in the cycle following edge E0+N*N+1 (default N=2: edge E0+5).
REQ-023 product SHALL change only on the SIGN edge and SHALL hold its value through IDLE until the next SIGN edge.
REQ-024 start SHALL be ignored while busy=1; there SHALL be no queueing and no restart.
REQ-025 start in the DONE cycle SHALL be ignored; a new operation can be accepted on the first IDLE cycle, so the back-to-back throughput is N*N+3 cycles.
REQ-026 Changes on a, b or signed_mode after the accepting edge SHALL NOT affect the result in progress.
REQ-027 A zero result SHALL yield product = 0 regardless of neg.

Reset
REQ-028 While reset=0, the following SHALL hold asynchronously: state=IDLE, busy=0, done=0, product=0, accumulator=0, k=0, latched operands=0, neg=0.
REQ-029 Reset asserted mid-operation SHALL abort it with no done pulse, and product SHALL read 0.
REQ-030 After reset release, the first edge with start=1 SHALL be accepted.

Verification
REQ-031 Defaults, unsigned, a=b=0xFFFFFFFF -> done high at E0+5 for 1 cycle; product=0xFFFFFFFE00000001; busy high E0+1..E0+5.
REQ-032 Signed, a=0xFFFFFFFF (-1), b=0x00000005 -> product=0xFFFFFFFFFFFFFFFB.
REQ-033 Signed, a=b=0x80000000 -> product=0x4000000000000000.
REQ-034 Second start pulsed with a=7, b=7 during busy of 3x4 unsigned -> exactly one done pulse; product=0x000000000000000C; the second start is ignored.
REQ-035 reset=0 at E0+3 of any operation -> busy, done and product immediately 0; no done pulse; a new start is accepted after release.
REQ-036 WIDTH=8, DIGIT=2, signed, a=0x9C (-100), b=0x03 -> done at E0+17; product=0xFED4 (-300).

Source files
------------

// File: rtl/mult_seq_arith.sv
// rtl/mult_seq_arith.sv - digit-serial signed/unsigned multiplier, one DIGIT x DIGIT partial product per cycle
module mult_seq_arith #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           r_state;
  logic [WIDTH-1:0]     r_a_mag;
  logic [WIDTH-1:0]     r_b_mag;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_product;
  logic [IW-1:0]        r_i;
  logic [IW-1:0]        r_j;

  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH-1:0]     w_a_sh;
  logic [WIDTH-1:0]     w_b_sh;
  logic [DIGIT-1:0]     w_a_dig;
  logic [DIGIT-1:0]     w_b_dig;
  logic [2*DIGIT-1:0]   w_pp;
  logic [2*WIDTH-1:0]   w_pp_sh;

  // Negating -2^(WIDTH-1) gives back the same bit pattern, which read unsigned is the correct magnitude.
  assign w_a_mag = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign w_b_mag = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  // Step k = r_j*N + r_i; keeping i and j as separate counters avoids a divider for k div N.
  assign w_a_sh  = r_a_mag >> (DIGIT * int'(r_i));
  assign w_b_sh  = r_b_mag >> (DIGIT * int'(r_j));
  assign w_a_dig = w_a_sh[DIGIT-1:0];
  assign w_b_dig = w_b_sh[DIGIT-1:0];
  assign w_pp    = (2*DIGIT)'(w_a_dig) * (2*DIGIT)'(w_b_dig);
  assign w_pp_sh = (2*WIDTH)'(w_pp) << (DIGIT * (int'(r_i) + int'(r_j)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_a_mag   <= '0;
      r_b_mag   <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_product <= '0;
      r_i       <= '0;
      r_j       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_mag <= w_a_mag;
            r_b_mag <= w_b_mag;
            r_neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= r_acc + w_pp_sh;
          if (r_i == LAST) begin
            r_i <= '0;
            if (r_j == LAST) begin
              r_j     <= '0;
              r_state <= S_SIGN;
            end else begin
              r_j <= r_j + IW'(1);
            end
          end else begin
            r_i <= r_i + IW'(1);
          end
        end
        S_SIGN: begin
          r_product <= r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_mult_seq_arith.sv
// tb/tb_mult_seq_arith.sv - scoreboard bench for mult_seq_arith (32/16 default and 8/2 instances)
module tb_mult_seq_arith;

  logic        clk;
  logic        reset;
  logic        st32, sm32, busy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] p32;
  logic        st8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic [63:0] q32[$];
  logic [15:0] q8[$];
  logic [63:0] last32;
  logic [15:0] last8;
  int ncomp;
  int nfail;

  mult_seq_arith dut32 (
    .clk(clk), .reset(reset), .start(st32), .signed_mode(sm32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .product(p32)
  );

  mult_seq_arith #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .reset(reset), .start(st8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(p8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m32(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint px, py;
    if (s) begin
      px = longint'($signed(x));
      py = longint'($signed(y));
    end else begin
      px = longint'({32'd0, x});
      py = longint'({32'd0, y});
    end
    return 64'(px * py);
  endfunction

  function automatic logic [15:0] m8(input logic [7:0] x, input logic [7:0] y, input logic s);
    int px, py;
    if (s) begin
      px = int'($signed(x));
      py = int'($signed(y));
    end else begin
      px = int'({24'd0, x});
      py = int'({24'd0, y});
    end
    return 16'(px * py);
  endfunction

  task automatic start32(input logic [31:0] x, input logic [31:0] y, input logic s, input logic [63:0] exp);
    a32 = x; b32 = y; sm32 = s; st32 = 1'b1;
    q32.push_back(exp);
    @(posedge clk); #1;
    st32 = 1'b0;
  endtask

  task automatic wait32(input int exp_lat);
    int cyc;
    logic [63:0] e;
    cyc = 0;
    while (done32 !== 1'b1 && cyc < 60) begin
      check("busy32_run", 64'(busy32), 64'd1);
      @(posedge clk); #1;
      cyc++;
    end
    check("lat32", 64'(cyc), 64'(exp_lat));
    check("busy32_done", 64'(busy32), 64'd1);
    check("q32_depth", 64'(q32.size()), 64'd1);
    e = (q32.size() > 0) ? q32.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    check("prod32", p32, e);
    last32 = e;
  endtask

  task automatic idle32;
    repeat (2) begin
      @(posedge clk); #1;
      check("done32_pulse", 64'(done32), 64'd0);
      check("busy32_idle", 64'(busy32), 64'd0);
      check("prod32_hold", p32, last32);
    end
  endtask

  task automatic start8(input logic [7:0] x, input logic [7:0] y, input logic s, input logic [15:0] exp);
    a8 = x; b8 = y; sm8 = s; st8 = 1'b1;
    q8.push_back(exp);
    @(posedge clk); #1;
    st8 = 1'b0;
  endtask

  task automatic wait8(input int exp_lat);
    int cyc;
    logic [15:0] e;
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 60) begin
      check("busy8_run", 64'(busy8), 64'd1);
      @(posedge clk); #1;
      cyc++;
    end
    check("lat8", 64'(cyc), 64'(exp_lat));
    check("q8_depth", 64'(q8.size()), 64'd1);
    e = (q8.size() > 0) ? q8.pop_front() : 16'hDEAD;
    check("prod8", 64'(p8), 64'(e));
    last8 = e;
    @(posedge clk); #1;
    check("done8_pulse", 64'(done8), 64'd0);
    check("prod8_hold", 64'(p8), 64'(last8));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] junk;
    ncomp = 0; nfail = 0;
    last32 = '0; last8 = '0;
    st32 = 0; sm32 = 0; a32 = '0; b32 = '0;
    st8 = 0; sm8 = 0; a8 = '0; b8 = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_busy32", 64'(busy32), 64'd0);
    check("rst_done32", 64'(done32), 64'd0);
    check("rst_prod32", p32, 64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_prod8", 64'(p8), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Directed 32-bit cases with reference products written out by hand
    start32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    wait32(5); idle32();
    start32(32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB);
    wait32(5); idle32();
    start32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    wait32(5); idle32();
    start32(32'h0000_0000, 32'hFFFF_FFFB, 1'b1, 64'd0);
    wait32(5); idle32();

    // Start during busy with different operands must be ignored
    start32(32'd3, 32'd4, 1'b0, 64'h0000_0000_0000_000C);
    a32 = 32'd7; b32 = 32'd7; sm32 = 1'b1; st32 = 1'b1;
    @(posedge clk); #1;
    st32 = 1'b0;
    wait32(4); idle32();
    repeat (3) begin
      @(posedge clk); #1;
      check("no_second_done", 64'(done32), 64'd0);
    end
    check("q32_empty", 64'(q32.size()), 64'd0);

    // Start held through DONE is ignored there and taken on the first IDLE edge
    start32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, m32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0));
    wait32(5);
    a32 = 32'hFFFF_FF9C; b32 = 32'd300; sm32 = 1'b1; st32 = 1'b1;
    q32.push_back(m32(32'hFFFF_FF9C, 32'd300, 1'b1));
    @(posedge clk); #1;
    check("done_start_ignored", 64'(busy32), 64'd0);
    @(posedge clk); #1;
    st32 = 1'b0;
    wait32(5); idle32();

    // Asynchronous reset mid-operation
    start32(32'hDEAD_BEEF, 32'h0000_0011, 1'b0, m32(32'hDEAD_BEEF, 32'h0000_0011, 1'b0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy32), 64'd0);
    check("abort_done", 64'(done32), 64'd0);
    check("abort_prod", p32, 64'd0);
    junk = (q32.size() > 0) ? q32.pop_front() : 64'd0;
    @(posedge clk); #1;
    check("abort_no_done", 64'(done32), 64'd0);
    reset = 1'b1;
    start32(32'd1000, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FC18);
    wait32(5); idle32();

    for (int n = 0; n < 4; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      start32(ra, rb, rs, m32(ra, rb, rs));
      wait32(5); idle32();
    end

    // Narrow instance: N=4, so done follows edge E0+17
    start8(8'h9C, 8'h03, 1'b1, 16'hFED4);
    wait8(17);
    start8(8'hFF, 8'hFF, 1'b0, m8(8'hFF, 8'hFF, 1'b0));
    wait8(17);
    start8(8'h80, 8'h7F, 1'b1, m8(8'h80, 8'h7F, 1'b1));
    wait8(17);
    start8(8'h80, 8'h80, 1'b1, 16'h4000);
    wait8(17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
